// File: rtl/noc_vc_input_queue.sv
// rtl/noc_vc_input_queue.sv - per-VC router input FIFOs with flow control and wormhole round-robin selection
package noc_vc_pkg;
  typedef enum logic {
    kFlowControlAckNack     = 1'b0,
    kFlowControlCreditBased = 1'b1
  } noc_flow_control_t;
endpackage

module noc_vc_input_queue
  import noc_vc_pkg::*;
#(
  parameter int                DataWidth   = 64,
  parameter int                Depth       = 4,
  parameter int                NumVc       = 2,
  parameter noc_flow_control_t FlowControl = kFlowControlCreditBased,
  localparam int               VcW         = (NumVc > 1) ? $clog2(NumVc) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DataWidth-1:0] data_in,
  input  logic [VcW-1:0]       vc_in,
  input  logic                 data_void_in,
  output logic [NumVc-1:0]     stop_out,
  output logic [NumVc-1:0]     credit_out,
  output logic [DataWidth-1:0] data_out,
  output logic [VcW-1:0]       vc_out,
  output logic                 data_void_out,
  input  logic                 stop_in,
  output logic                 overflow
);

  localparam int              PtrW       = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int              CntW       = $clog2(Depth + 1);
  localparam logic [CntW-1:0] CntFull    = CntW'(Depth);
  localparam logic [CntW-1:0] CntStop    = CntW'(Depth - 1);
  localparam logic [PtrW-1:0] PtrLast    = PtrW'(Depth - 1);
  localparam logic [VcW-1:0]  VcLast     = VcW'(NumVc - 1);
  localparam bit              CreditMode = (FlowControl == kFlowControlCreditBased);

  // Flit storage and per-VC bookkeeping
  logic [DataWidth-1:0] mem    [NumVc][Depth];
  logic [PtrW-1:0]      wr_ptr [NumVc];
  logic [PtrW-1:0]      rd_ptr [NumVc];
  logic [CntW-1:0]      count  [NumVc];

  // Arbitration state: last served VC and the wormhole lock
  logic [VcW-1:0]   rr_ptr;
  logic [VcW-1:0]   lock_vc;
  logic             lock_valid;
  logic [NumVc-1:0] credit_q;
  logic             overflow_q;

  logic             in_valid;
  logic             in_full;
  logic             enq;
  logic [NumVc-1:0] not_empty;
  logic [NumVc-1:0] push_vec;
  logic [NumVc-1:0] pop_vec;
  logic             cand_valid;
  logic [VcW-1:0]   cand_vc;
  int               scan_idx;
  logic             deq;
  logic             flit_head;
  logic             flit_tail;

  // A flit to a full VC is dropped even if that VC pops in the same cycle
  assign in_valid = !data_void_in && (int'(vc_in) < NumVc);
  assign in_full  = in_valid && (count[vc_in] == CntFull);
  assign enq      = in_valid && !in_full;

  // Per-VC occupancy flags and push/pop strobes
  always_comb begin
    not_empty = '0;
    push_vec  = '0;
    pop_vec   = '0;
    for (int v = 0; v < NumVc; v++) begin
      not_empty[v] = (count[v] != '0);
      push_vec[v]  = enq && (vc_in == VcW'(v));
      pop_vec[v]   = deq && (cand_vc == VcW'(v));
    end
  end

  // Candidate selection: locked VC, else first non-empty VC after rr_ptr
  always_comb begin
    cand_valid = 1'b0;
    cand_vc    = lock_vc;
    scan_idx   = 0;
    if (lock_valid) begin
      cand_valid = not_empty[lock_vc];
    end else begin
      // Scan farthest-first so the nearest non-empty VC is the last assignment
      for (int off = NumVc; off >= 1; off--) begin
        scan_idx = (int'(rr_ptr) + off) % NumVc;
        if (not_empty[scan_idx]) begin
          cand_valid = 1'b1;
          cand_vc    = VcW'(scan_idx);
        end
      end
    end
  end

  assign data_out      = mem[cand_vc][rd_ptr[cand_vc]];
  assign vc_out        = cand_vc;
  assign data_void_out = !cand_valid;
  assign deq           = cand_valid && !stop_in;
  assign flit_head     = data_out[DataWidth-1];
  assign flit_tail     = data_out[DataWidth-2];

  // Flit payload write; storage needs no reset since counts gate visibility
  always_ff @(posedge clk) begin
    if (enq) begin
      mem[vc_in][wr_ptr[vc_in]] <= data_in;
    end
  end

  // Per-VC pointers and occupancy counts, wrapping explicitly at Depth-1
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int v = 0; v < NumVc; v++) begin
        wr_ptr[v] <= '0;
        rd_ptr[v] <= '0;
        count[v]  <= '0;
      end
    end else begin
      for (int v = 0; v < NumVc; v++) begin
        if (push_vec[v]) begin
          wr_ptr[v] <= (wr_ptr[v] == PtrLast) ? '0 : wr_ptr[v] + PtrW'(1);
        end
        if (pop_vec[v]) begin
          rd_ptr[v] <= (rd_ptr[v] == PtrLast) ? '0 : rd_ptr[v] + PtrW'(1);
        end
        case ({push_vec[v], pop_vec[v]})
          2'b10:   count[v] <= count[v] + CntW'(1);
          2'b01:   count[v] <= count[v] - CntW'(1);
          default: count[v] <= count[v];
        endcase
      end
    end
  end

  // Round-robin pointer and wormhole lock follow each dequeued flit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr     <= VcLast;
      lock_valid <= 1'b0;
      lock_vc    <= '0;
    end else if (deq) begin
      rr_ptr <= cand_vc;
      if (flit_tail) begin
        lock_valid <= 1'b0;
      end else if (flit_head) begin
        lock_valid <= 1'b1;
        lock_vc    <= cand_vc;
      end
    end
  end

  // Credit return pulses and the sticky overflow flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credit_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      credit_q <= CreditMode ? pop_vec : '0;
      if (in_full) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Ack/nack back-pressure keeps one slot free for the flit already in flight
  always_comb begin
    stop_out = '0;
    if (!CreditMode) begin
      for (int v = 0; v < NumVc; v++) begin
        stop_out[v] = (count[v] >= CntStop);
      end
    end
  end

  assign credit_out = credit_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_noc_vc_input_queue.sv
// tb/tb_noc_vc_input_queue.sv - directed bench for credit and ack/nack input queues
module tb_noc_vc_input_queue;
  import noc_vc_pkg::*;

  logic clk = 1'b0;
  logic rst;

  logic [15:0] c_data_in, c_data_out;
  logic        c_vc_in, c_vc_out, c_void_in, c_void_out, c_stop_in, c_overflow;
  logic [1:0]  c_stop_out, c_credit_out;

  logic [15:0] a_data_in, a_data_out;
  logic        a_vc_in, a_vc_out, a_void_in, a_void_out, a_stop_in, a_overflow;
  logic [1:0]  a_stop_out, a_credit_out;

  int errors = 0;
  int checks = 0;

  noc_vc_input_queue #(
    .DataWidth(16), .Depth(4), .NumVc(2), .FlowControl(kFlowControlCreditBased)
  ) dut_cr (
    .clk(clk), .rst(rst), .data_in(c_data_in), .vc_in(c_vc_in),
    .data_void_in(c_void_in), .stop_out(c_stop_out), .credit_out(c_credit_out),
    .data_out(c_data_out), .vc_out(c_vc_out), .data_void_out(c_void_out),
    .stop_in(c_stop_in), .overflow(c_overflow)
  );

  noc_vc_input_queue #(
    .DataWidth(16), .Depth(4), .NumVc(2), .FlowControl(kFlowControlAckNack)
  ) dut_an (
    .clk(clk), .rst(rst), .data_in(a_data_in), .vc_in(a_vc_in),
    .data_void_in(a_void_in), .stop_out(a_stop_out), .credit_out(a_credit_out),
    .data_out(a_data_out), .vc_out(a_vc_out), .data_void_out(a_void_out),
    .stop_in(a_stop_in), .overflow(a_overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ht(input int id);
    return {2'b11, 14'(id)};
  endfunction
  function automatic logic [15:0] hd(input int id);
    return {2'b10, 14'(id)};
  endfunction
  function automatic logic [15:0] bd(input int id);
    return {2'b00, 14'(id)};
  endfunction
  function automatic logic [15:0] tl(input int id);
    return {2'b01, 14'(id)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_c(input logic vc, input logic [15:0] d);
    c_vc_in   = vc;
    c_data_in = d;
    c_void_in = 1'b0;
    tick();
    c_void_in = 1'b1;
  endtask

  task automatic send_a(input logic vc, input logic [15:0] d);
    a_vc_in   = vc;
    a_data_in = d;
    a_void_in = 1'b0;
    tick();
    a_void_in = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    c_data_in = '0; c_vc_in = 1'b0; c_void_in = 1'b1; c_stop_in = 1'b1;
    a_data_in = '0; a_vc_in = 1'b0; a_void_in = 1'b1; a_stop_in = 1'b1;
    tick();
    tick();

    chk("rst_c_void", c_void_out, 1);
    chk("rst_c_credit", c_credit_out, 0);
    chk("rst_c_overflow", c_overflow, 0);
    chk("rst_c_stop", c_stop_out, 0);
    chk("rst_a_void", a_void_out, 1);
    chk("rst_a_stop", a_stop_out, 0);
    rst = 1'b1;

    // Four single-flit packets on VC0, then drain back-to-back
    for (int i = 0; i < 4; i++) send_c(1'b0, ht(16'hA0 + i));
    chk("t1_valid", c_void_out, 0);
    chk("t1_credit_idle", c_credit_out, 0);
    c_stop_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_data%0d", i), c_data_out, ht(16'hA0 + i));
      chk($sformatf("t1_vc%0d", i), c_vc_out, 0);
      tick();
      chk($sformatf("t1_credit%0d", i), c_credit_out, 2'b01);
    end
    chk("t1_empty", c_void_out, 1);
    tick();
    chk("t1_credit_end", c_credit_out, 0);
    chk("t1_overflow", c_overflow, 0);

    // Overflow with and without a same-cycle dequeue
    c_stop_in = 1'b1;
    for (int i = 0; i < 4; i++) send_c(1'b0, ht(16'hB0 + i));
    chk("t2_no_ovf_yet", c_overflow, 0);
    send_c(1'b0, ht(16'hB4));
    chk("t2_ovf_set", c_overflow, 1);
    chk("t2_head_kept", c_data_out, ht(16'hB0));
    c_stop_in = 1'b0;
    send_c(1'b0, ht(16'hB5));
    chk("t2_ovf_sticky", c_overflow, 1);
    chk("t2_credit", c_credit_out, 2'b01);
    for (int i = 1; i < 4; i++) begin
      chk($sformatf("t2_data%0d", i), c_data_out, ht(16'hB0 + i));
      tick();
    end
    chk("t2_dropped", c_void_out, 1);
    chk("t2_ovf_still", c_overflow, 1);
    c_stop_in = 1'b1;
    do_reset();
    chk("t2_ovf_cleared", c_overflow, 0);

    // Wormhole lock holds VC0 while VC1 waits
    send_c(1'b1, ht(16'h51));
    send_c(1'b0, hd(16'h11));
    chk("t3_head", c_data_out, hd(16'h11));
    chk("t3_head_vc", c_vc_out, 0);
    c_stop_in = 1'b0;
    tick();
    chk("t3_void1", c_void_out, 1);
    tick();
    chk("t3_void2", c_void_out, 1);
    send_c(1'b0, bd(16'h12));
    chk("t3_body", c_data_out, bd(16'h12));
    send_c(1'b0, tl(16'h13));
    chk("t3_tail", c_data_out, tl(16'h13));
    tick();
    chk("t3_vc1_data", c_data_out, ht(16'h51));
    chk("t3_vc1_vc", c_vc_out, 1);
    tick();
    chk("t3_drained", c_void_out, 1);

    // Round robin between two preloaded VCs
    c_stop_in = 1'b1;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send_c(1'b0, ht(16'h40 + i));
      send_c(1'b1, ht(16'h48 + i));
    end
    c_stop_in = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("t4_vc%0d", k), c_vc_out, k % 2);
      chk($sformatf("t4_data%0d", k), c_data_out,
          (k % 2 == 1) ? ht(16'h48 + k / 2) : ht(16'h40 + k / 2));
      tick();
    end
    chk("t4_empty", c_void_out, 1);
    c_stop_in = 1'b1;

    // Ack/nack back-pressure on VC1
    send_a(1'b1, ht(16'h61));
    chk("t5_stop_1", a_stop_out, 2'b00);
    send_a(1'b1, ht(16'h62));
    chk("t5_stop_2", a_stop_out, 2'b00);
    send_a(1'b1, ht(16'h63));
    chk("t5_stop_3", a_stop_out, 2'b10);
    chk("t5_credit", a_credit_out, 2'b00);
    chk("t5_data", a_data_out, ht(16'h61));
    chk("t5_vc", a_vc_out, 1);
    a_stop_in = 1'b0;
    tick();
    a_stop_in = 1'b1;
    chk("t5_stop_rel", a_stop_out, 2'b00);
    chk("t5_credit_rel", a_credit_out, 2'b00);
    chk("t5_data_next", a_data_out, ht(16'h62));
    send_a(1'b1, ht(16'h64));
    chk("t5_stop_again", a_stop_out, 2'b10);

    // Reset with both VCs full and VC0 locked
    send_c(1'b0, hd(16'h70));
    c_stop_in = 1'b0;
    tick();
    c_stop_in = 1'b1;
    chk("t6_locked_void", c_void_out, 1);
    for (int i = 0; i < 4; i++) send_c(1'b0, bd(16'h71 + i));
    for (int i = 0; i < 4; i++) send_c(1'b1, ht(16'h78 + i));
    chk("t6_locked_data", c_data_out, bd(16'h71));
    send_c(1'b0, tl(16'h7F));
    chk("t6_ovf", c_overflow, 1);
    rst = 1'b0;
    #1;
    chk("t6_rst_void", c_void_out, 1);
    chk("t6_rst_stop", c_stop_out, 0);
    chk("t6_rst_credit", c_credit_out, 0);
    chk("t6_rst_ovf", c_overflow, 0);
    chk("t6_rst_a_void", a_void_out, 1);
    chk("t6_rst_a_stop", a_stop_out, 0);
    tick();
    chk("t6_rst_hold", c_void_out, 1);
    rst = 1'b1;
    send_c(1'b1, ht(16'h55));
    chk("t6_post_valid", c_void_out, 0);
    chk("t6_post_vc", c_vc_out, 1);
    chk("t6_post_data", c_data_out, ht(16'h55));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
